// File: rtl/regfile_sb.sv
// regfile_sb: 2**REGWIDTH x DATAWIDTH register file with two combinational
// read ports, one write port with bypass, link-register capture, and a
// per-register pending (scoreboard) bit with a registered busy count.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   rSrc/dSrc         read port A address/data
//   rDst/dDst         read port B address/data
//   write/wAddr/
//   write_data        write-back port (clears pending bit of wAddr)
//   pc                link value stored on writes to the all-ones address
//   pend_set/
//   pend_addr         mark a register pending (load issued)
//   hazard            a non-bypassed read operand is pending
//   busy_cnt          number of pending registers
module regfile_sb #(
  parameter int DATAWIDTH = 16,
  parameter int REGWIDTH  = 4,
  parameter int LINK_EN   = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [REGWIDTH-1:0]  rSrc,
  input  logic [REGWIDTH-1:0]  rDst,
  output logic [DATAWIDTH-1:0] dSrc,
  output logic [DATAWIDTH-1:0] dDst,
  input  logic                 write,
  input  logic [REGWIDTH-1:0]  wAddr,
  input  logic [DATAWIDTH-1:0] write_data,
  input  logic [DATAWIDTH-1:0] pc,
  input  logic                 pend_set,
  input  logic [REGWIDTH-1:0]  pend_addr,
  output logic                 hazard,
  output logic [REGWIDTH:0]    busy_cnt
);

  localparam int NREG = 2 ** REGWIDTH;
  localparam logic [REGWIDTH-1:0] LINK_ADDR = '1;

  logic [DATAWIDTH-1:0] regs_q [NREG];
  logic [NREG-1:0]      pend_q, pend_d;
  logic [REGWIDTH:0]    busy_q, busy_d;
  logic                 wr_en, set_en;
  logic                 byp_s, byp_d;
  logic [DATAWIDTH-1:0] wval;

  assign wr_en  = write && (wAddr != '0);
  assign set_en = pend_set && (pend_addr != '0);
  assign wval   = ((LINK_EN != 0) && (wAddr == LINK_ADDR)) ? pc : write_data;
  assign byp_s  = wr_en && (wAddr == rSrc);
  assign byp_d  = wr_en && (wAddr == rDst);

  // Outputs are forced to 0 while in reset so a same-cycle bypass
  // cannot leak a discarded write onto the read ports.
  always_comb begin
    dSrc   = '0;
    dDst   = '0;
    hazard = 1'b0;
    if (rst_n) begin
      if (rSrc != '0) dSrc = byp_s ? wval : regs_q[rSrc];
      if (rDst != '0) dDst = byp_d ? wval : regs_q[rDst];
      hazard = ((rSrc != '0) && pend_q[rSrc] && !byp_s) ||
               ((rDst != '0) && pend_q[rDst] && !byp_d);
    end
  end

  // Clear first, then set, so a same-address set wins.
  always_comb begin
    pend_d = pend_q;
    if (wr_en)  pend_d[wAddr]     = 1'b0;
    if (set_en) pend_d[pend_addr] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_comb begin
    busy_d = '0;
    for (int i = 0; i < NREG; i++)
      busy_d = busy_d + {{REGWIDTH{1'b0}}, pend_d[i]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[wAddr] <= wval;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
      busy_q <= '0;
    end else begin
      pend_q <= pend_d;
      busy_q <= busy_d;
    end
  end

  assign busy_cnt = busy_q;

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: table-driven + model-driven bench for regfile_sb.
// Two instances share stimulus: LINK_EN=1 and LINK_EN=0.
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  rSrc, rDst, wAddr, pend_addr;
  logic [15:0] write_data, pc;
  logic        write, pend_set;
  logic [15:0] dSrc0, dDst0, dSrc1, dDst1;
  logic        hz0, hz1;
  logic [4:0]  bc0, bc1;

  regfile_sb #(.DATAWIDTH(16), .REGWIDTH(4), .LINK_EN(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .rSrc(rSrc), .rDst(rDst),
    .dSrc(dSrc0), .dDst(dDst0), .write(write), .wAddr(wAddr),
    .write_data(write_data), .pc(pc), .pend_set(pend_set),
    .pend_addr(pend_addr), .hazard(hz0), .busy_cnt(bc0)
  );

  regfile_sb #(.DATAWIDTH(16), .REGWIDTH(4), .LINK_EN(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .rSrc(rSrc), .rDst(rDst),
    .dSrc(dSrc1), .dDst(dDst1), .write(write), .wAddr(wAddr),
    .write_data(write_data), .pc(pc), .pend_set(pend_set),
    .pend_addr(pend_addr), .hazard(hz1), .busy_cnt(bc1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [3:0]  wa;
    logic [15:0] wd;
    logic [15:0] pc;
    logic        ps;
    logic [3:0]  pa;
    logic [3:0]  rs;
    logic [3:0]  rd;
  } in_t;

  typedef struct {
    logic [15:0] ds0;
    logic [15:0] dd0;
    logic [15:0] ds1;
    logic [15:0] dd1;
    logic        hz;
    logic [4:0]  bc;
  } exp_t;

  typedef struct {
    in_t  i;
    exp_t e;
  } vec_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic in_t mki(logic wr, logic [3:0] wa, logic [15:0] wd,
                              logic [15:0] p, logic ps, logic [3:0] pa,
                              logic [3:0] rs, logic [3:0] rd);
    in_t r;
    r.wr = wr; r.wa = wa; r.wd = wd; r.pc = p;
    r.ps = ps; r.pa = pa; r.rs = rs; r.rd = rd;
    return r;
  endfunction

  function automatic exp_t mke(logic [15:0] ds0, logic [15:0] ds1,
                               logic [15:0] dd, logic hz, logic [4:0] bc);
    exp_t r;
    r.ds0 = ds0; r.ds1 = ds1; r.dd0 = dd; r.dd1 = dd;
    r.hz = hz; r.bc = bc;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Drive one cycle at negedge, queue expectation, sample 1ns later.
  task automatic step(input in_t i, input logic rn, input exp_t e,
                      input string tag);
    exp_t g;
    @(negedge clk);
    rst_n      = rn;
    write      = i.wr;
    wAddr      = i.wa;
    write_data = i.wd;
    pc         = i.pc;
    pend_set   = i.ps;
    pend_addr  = i.pa;
    rSrc       = i.rs;
    rDst       = i.rd;
    exp_q.push_back(e);
    #1;
    g = exp_q.pop_front();
    chk({tag, ".dSrc0"}, 32'(dSrc0), 32'(g.ds0));
    chk({tag, ".dDst0"}, 32'(dDst0), 32'(g.dd0));
    chk({tag, ".dSrc1"}, 32'(dSrc1), 32'(g.ds1));
    chk({tag, ".dDst1"}, 32'(dDst1), 32'(g.dd1));
    chk({tag, ".hazard0"}, 32'(hz0), 32'(g.hz));
    chk({tag, ".hazard1"}, 32'(hz1), 32'(g.hz));
    chk({tag, ".busy0"}, 32'(bc0), 32'(g.bc));
    chk({tag, ".busy1"}, 32'(bc1), 32'(g.bc));
  endtask

  in_t  idle;
  exp_t zero;

  task automatic do_reset();
    step(idle, 1'b0, zero, "rst");
    step(idle, 1'b0, zero, "rst");
    step(idle, 1'b1, zero, "rst_rel");
  endtask

  vec_t tbl[21];

  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] m0 [16];
    logic [15:0] m1 [16];
    logic [15:0] pm;
    idle = mki(0, 0, 0, 0, 0, 0, 0, 0);
    zero = mke(0, 0, 0, 0, 0);
    rst_n = 1'b0;
    write = 0; wAddr = 0; write_data = 0; pc = 0;
    pend_set = 0; pend_addr = 0; rSrc = 0; rDst = 0;

    //            wr wa wd        pc        ps pa rs  rd
    tbl[0]  = '{mki(0, 0, 16'h0000, 16'h0000, 0, 0, 3, 15),
                mke(16'h0000, 16'h0000, 16'h0000, 0, 0)};
    tbl[1]  = '{mki(1, 3, 16'hA5A5, 16'h0000, 0, 0, 3, 0),
                mke(16'hA5A5, 16'hA5A5, 16'h0000, 0, 0)};
    tbl[2]  = '{mki(0, 0, 16'h0000, 16'h0000, 0, 0, 3, 0),
                mke(16'hA5A5, 16'hA5A5, 16'h0000, 0, 0)};
    tbl[3]  = '{mki(1, 15, 16'h1111, 16'h0040, 0, 0, 0, 0),
                mke(16'h0000, 16'h0000, 16'h0000, 0, 0)};
    tbl[4]  = '{mki(0, 0, 16'h0000, 16'h0000, 0, 0, 15, 3),
                mke(16'h0040, 16'h1111, 16'hA5A5, 0, 0)};
    tbl[5]  = '{mki(1, 0, 16'hFFFF, 16'h0000, 1, 0, 0, 0),
                mke(16'h0000, 16'h0000, 16'h0000, 0, 0)};
    tbl[6]  = '{mki(0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0),
                mke(16'h0000, 16'h0000, 16'h0000, 0, 0)};
    tbl[7]  = '{mki(0, 0, 16'h0000, 16'h0000, 1, 5, 0, 0),
                mke(16'h0000, 16'h0000, 16'h0000, 0, 0)};
    tbl[8]  = '{mki(0, 0, 16'h0000, 16'h0000, 0, 0, 0, 5),
                mke(16'h0000, 16'h0000, 16'h0000, 1, 1)};
    tbl[9]  = '{mki(1, 5, 16'h0007, 16'h0000, 0, 0, 0, 5),
                mke(16'h0000, 16'h0000, 16'h0007, 0, 1)};
    tbl[10] = '{mki(0, 0, 16'h0000, 16'h0000, 0, 0, 0, 5),
                mke(16'h0000, 16'h0000, 16'h0007, 0, 0)};
    tbl[11] = '{mki(1, 6, 16'h1234, 16'h0000, 1, 6, 0, 0),
                mke(16'h0000, 16'h0000, 16'h0000, 0, 0)};
    tbl[12] = '{mki(0, 0, 16'h0000, 16'h0000, 0, 0, 6, 0),
                mke(16'h1234, 16'h1234, 16'h0000, 1, 1)};
    tbl[13] = '{mki(0, 0, 16'h0000, 16'h0000, 1, 6, 6, 0),
                mke(16'h1234, 16'h1234, 16'h0000, 1, 1)};
    tbl[14] = '{mki(0, 0, 16'h0000, 16'h0000, 0, 0, 6, 0),
                mke(16'h1234, 16'h1234, 16'h0000, 1, 1)};
    tbl[15] = '{mki(1, 6, 16'h5678, 16'h0000, 1, 7, 6, 7),
                mke(16'h5678, 16'h5678, 16'h0000, 0, 1)};
    tbl[16] = '{mki(0, 0, 16'h0000, 16'h0000, 0, 0, 6, 7),
                mke(16'h5678, 16'h5678, 16'h0000, 1, 1)};
    tbl[17] = '{mki(1, 3, 16'hBEEF, 16'h0000, 0, 0, 7, 3),
                mke(16'h0000, 16'h0000, 16'hBEEF, 1, 1)};
    tbl[18] = '{mki(0, 0, 16'h0000, 16'h0000, 0, 0, 3, 0),
                mke(16'hBEEF, 16'hBEEF, 16'h0000, 0, 1)};
    tbl[19] = '{mki(1, 15, 16'h2222, 16'h0080, 0, 0, 15, 7),
                mke(16'h0080, 16'h2222, 16'h0000, 1, 1)};
    tbl[20] = '{mki(0, 0, 16'h0000, 16'h0000, 0, 0, 15, 0),
                mke(16'h0080, 16'h2222, 16'h0000, 0, 1)};

    do_reset();
    for (int k = 0; k < 21; k++)
      step(tbl[k].i, 1'b1, tbl[k].e, $sformatf("vec%0d", k));

    // Fill the scoreboard, then reset asynchronously mid-operation.
    do_reset();
    for (int k = 1; k < 16; k++)
      step(mki(0, 0, 0, 0, 1, 4'(k), 4'(k), 0), 1'b1,
           mke(0, 0, 0, 0, 5'(k - 1)), $sformatf("fill%0d", k));
    step(mki(0, 0, 0, 0, 0, 0, 1, 15), 1'b1,
         mke(0, 0, 0, 1, 15), "full");
    step(mki(1, 3, 16'hAAAA, 0, 1, 2, 3, 15), 1'b0,
         zero, "midrst");
    step(mki(1, 3, 16'hAAAA, 0, 1, 2, 3, 2), 1'b0,
         zero, "midrst_hold");
    step(mki(0, 0, 0, 0, 0, 0, 3, 2), 1'b1, zero, "post_rst");
    step(mki(1, 3, 16'hCAFE, 0, 1, 2, 0, 0), 1'b1, zero, "post_wr");
    step(mki(0, 0, 0, 0, 0, 0, 3, 2), 1'b1,
         mke(16'hCAFE, 16'hCAFE, 0, 1, 1), "post_chk");

    // Randomised cycles against a reference model.
    do_reset();
    for (int a = 0; a < 16; a++) begin
      m0[a] = '0;
      m1[a] = '0;
    end
    pm = '0;
    for (int c = 0; c < 300; c++) begin
      in_t  i;
      exp_t e;
      logic wv;
      i.wr = 1'($urandom_range(0, 1));
      i.wa = 4'($urandom_range(0, 15));
      i.wd = 16'($urandom);
      i.pc = 16'($urandom);
      i.ps = 1'($urandom_range(0, 1));
      i.pa = 4'($urandom_range(0, 15));
      i.rs = ($urandom_range(0, 3) == 0) ? i.wa : 4'($urandom_range(0, 15));
      i.rd = ($urandom_range(0, 3) == 0) ? i.pa : 4'($urandom_range(0, 15));
      wv = i.wr && (i.wa != 0);
      e.ds0 = (i.rs == 0) ? 16'h0 : (wv && i.wa == i.rs) ?
              ((i.wa == 15) ? i.pc : i.wd) : m0[i.rs];
      e.dd0 = (i.rd == 0) ? 16'h0 : (wv && i.wa == i.rd) ?
              ((i.wa == 15) ? i.pc : i.wd) : m0[i.rd];
      e.ds1 = (i.rs == 0) ? 16'h0 : (wv && i.wa == i.rs) ? i.wd : m1[i.rs];
      e.dd1 = (i.rd == 0) ? 16'h0 : (wv && i.wa == i.rd) ? i.wd : m1[i.rd];
      e.hz  = ((i.rs != 0) && pm[i.rs] && !(wv && i.wa == i.rs)) ||
              ((i.rd != 0) && pm[i.rd] && !(wv && i.wa == i.rd));
      e.bc  = 5'($countones(pm));
      step(i, 1'b1, e, $sformatf("rnd%0d", c));
      if (wv) begin
        m0[i.wa] = (i.wa == 15) ? i.pc : i.wd;
        m1[i.wa] = i.wd;
        pm[i.wa] = 1'b0;
      end
      if (i.ps && i.pa != 0) pm[i.pa] = 1'b1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
